pulse_filter_line_buffer: RTL



---
 rtl/pulse_filter_pkg.sv | 20 ++
 rtl/pulse_filter_line_buffer_if.sv | 23 ++
 rtl/pulse_filter_line_ram.sv | 25 ++
 rtl/pulse_filter_line_buffer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pulse_filter_pkg.sv
// Shared constants and helpers for the pulse-filter line buffer.
package pulse_filter_pkg;

    // Edge handling for window rows that hold no valid data
    localparam int EDGE_ZERO      = 0;
    localparam int EDGE_REPLICATE = 1;

    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_LINE_DEPTH = 3072;
    localparam int DEF_LINE_NUM   = 4;

    // Ceiling log2; callers pass values >= 2
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/pulse_filter_line_buffer_if.sv
// Video stream in, column window out.
interface pulse_filter_line_buffer_if #(
    parameter int DATA_WIDTH = 10,
    parameter int LINE_NUM   = 4
);
    logic                           i_fval;
    logic                           i_lval;
    logic [DATA_WIDTH-1:0]          iv_pix_data;
    logic [LINE_NUM*DATA_WIDTH-1:0] ov_window;
    logic                           o_window_valid;
    logic                           o_rows_ready;
    logic                           o_overflow;

    modport master (
        output i_fval, i_lval, iv_pix_data,
        input  ov_window, o_window_valid, o_rows_ready, o_overflow
    );

    modport slave (
        input  i_fval, i_lval, iv_pix_data,
        output ov_window, o_window_valid, o_rows_ready, o_overflow
    );
endinterface

// File: rtl/pulse_filter_line_ram.sv
// Simple dual-port line RAM, registered read, no reset on contents.
module pulse_filter_line_ram #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 3072
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port and one-cycle read port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pulse_filter_line_buffer.sv
// Line buffer producing a LINE_NUM-tall column window per accepted pixel.
// Slice 0 is the live pixel; slice k comes from the line k rows back.
module pulse_filter_line_buffer
    import pulse_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_DEPTH = DEF_LINE_DEPTH,
    parameter int LINE_NUM   = DEF_LINE_NUM,
    parameter int EDGE_MODE  = EDGE_ZERO
) (
    input logic                        clk,
    input logic                        reset,
    pulse_filter_line_buffer_if.slave  bus
);
    localparam int ADDR_WIDTH = clog2(LINE_DEPTH);
    localparam int ROW_WIDTH  = clog2(LINE_NUM);
    localparam int CW         = ADDR_WIDTH + 1;   // column count reaches LINE_DEPTH
    localparam int STAGES     = 2;

    typedef logic [CW-1:0]         col_t;
    typedef logic [ROW_WIDTH-1:0]  row_t;
    typedef logic [DATA_WIDTH-1:0] pix_t;

    localparam col_t DEPTH_C  = col_t'(LINE_DEPTH);
    localparam row_t LAST_ROW = row_t'(LINE_NUM - 1);

    // control state
    logic                       fval_q, fval_d;
    logic                       act_q, act_d;
    logic                       frame_q, frame_d;
    col_t                       col_q, col_d;
    row_t                       wptr_q, wptr_d;
    row_t                       lines_q, lines_d;
    logic [LINE_NUM-1:0][CW-1:0] len_q, len_d;
    logic                       ovf_q, ovf_d;

    // pipeline state
    logic [STAGES:1]                     vld_pipe_q, vld_pipe_d;
    pix_t                                pix_s1_q, pix_s1_d;
    logic [LINE_NUM-1:1]                 miss_s1_q, miss_d;
    logic [LINE_NUM-1:1][ROW_WIDTH-1:0]  row_s1_q, row_d;
    logic [LINE_NUM*DATA_WIDTH-1:0]      win_q, win_d;

    // combinational helpers
    logic                  fval_rise, line_end, wr;
    col_t                  col_b;
    row_t                  wptr_b, lines_b;
    logic [LINE_NUM-1:0][CW-1:0] len_b;
    logic                  ovf_b;
    logic [ADDR_WIDTH-1:0] waddr;
    pix_t                  rd [LINE_NUM];

    // Frame/line tracking: a new frame zeroes state before this cycle's pixel
    always_comb begin
        fval_rise = bus.i_fval & ~fval_q;
        frame_d   = frame_q | fval_rise;
        fval_d    = bus.i_fval;
        act_d     = bus.i_fval & bus.i_lval & frame_d;

        col_b   = fval_rise ? '0 : col_q;
        wptr_b  = fval_rise ? '0 : wptr_q;
        lines_b = fval_rise ? '0 : lines_q;
        len_b   = fval_rise ? '0 : len_q;
        ovf_b   = fval_rise ? 1'b0 : ovf_q;

        // lval or fval dropping ends a line; empty lines leave state alone
        line_end = act_q & ~act_d & (col_q != '0);
        wr       = act_d & (col_b != DEPTH_C);

        col_d   = col_b;
        wptr_d  = wptr_b;
        lines_d = lines_b;
        len_d   = len_b;
        ovf_d   = ovf_b;

        if (act_d && !wr) ovf_d = 1'b1;
        if (wr) col_d = col_b + col_t'(1);
        if (line_end) begin
            len_d[wptr_b] = col_q;
            wptr_d  = (wptr_b == LAST_ROW) ? '0 : wptr_b + row_t'(1);
            lines_d = (lines_b == LAST_ROW) ? lines_b : lines_b + row_t'(1);
            col_d   = '0;
        end
    end

    // Which RAM holds each older slice, and whether that row has data here
    always_comb begin
        miss_d = '0;
        row_d  = '0;
        for (int k = 1; k < LINE_NUM; k++) begin
            row_d[k]  = row_t'((int'(wptr_b) + LINE_NUM - k) % LINE_NUM);
            miss_d[k] = (int'(lines_b) < k) || (col_b >= len_b[row_d[k]]);
        end
    end

    assign waddr      = col_b[ADDR_WIDTH-1:0];
    assign vld_pipe_d = {vld_pipe_q[STAGES-1:1], wr};
    assign pix_s1_d   = wr ? bus.iv_pix_data : pix_s1_q;

    for (genvar r = 0; r < LINE_NUM; r++) begin : g_ram
        pulse_filter_line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (LINE_DEPTH)
        ) u_ram (
            .clk   (clk),
            .we    (wr && (wptr_b == row_t'(r))),
            .waddr (waddr),
            .wdata (bus.iv_pix_data),
            .re    (wr),
            .raddr (waddr),
            .rdata (rd[r])
        );
    end

    // Assemble the window from RAM outputs, filling missing rows
    always_comb begin
        pix_t prev, cur;
        win_d = win_q;
        prev  = pix_s1_q;
        cur   = '0;
        if (vld_pipe_q[1]) begin
            win_d[DATA_WIDTH-1:0] = pix_s1_q;
            for (int k = 1; k < LINE_NUM; k++) begin
                if (!miss_s1_q[k])                  cur = rd[row_s1_q[k]];
                else if (EDGE_MODE == EDGE_REPLICATE) cur = prev;
                else                                 cur = '0;
                win_d[k*DATA_WIDTH +: DATA_WIDTH] = cur;
                prev = cur;
            end
        end
    end

    // State update; fval_q resets high so only a real rising edge opens a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            fval_q     <= 1'b1;
            act_q      <= 1'b0;
            frame_q    <= 1'b0;
            col_q      <= '0;
            wptr_q     <= '0;
            lines_q    <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            vld_pipe_q <= '0;
            pix_s1_q   <= '0;
            miss_s1_q  <= '0;
            row_s1_q   <= '0;
            win_q      <= '0;
        end else begin
            fval_q     <= fval_d;
            act_q      <= act_d;
            frame_q    <= frame_d;
            col_q      <= col_d;
            wptr_q     <= wptr_d;
            lines_q    <= lines_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            vld_pipe_q <= vld_pipe_d;
            pix_s1_q   <= pix_s1_d;
            if (wr) begin
                miss_s1_q <= miss_d;
                row_s1_q  <= row_d;
            end
            win_q      <= win_d;
        end
    end

    assign bus.ov_window      = win_q;
    assign bus.o_window_valid = vld_pipe_q[STAGES];
    assign bus.o_rows_ready   = (lines_q == LAST_ROW);
    assign bus.o_overflow     = ovf_q;
endmodule
